// File: rtl/ov7670_cfg_pkg.sv
// Shared FSM states, table markers and entry layout for the OV7670 configuration sequencer.
package ov7670_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_ISSUE,
    ST_WAIT,
    ST_ERR_HOLD,
    ST_GAP,
    ST_DELAY,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } cfg_entry_t;

endpackage

// File: rtl/ov7670_cfg_rom.sv
// OV7670 register table: {reg_addr, reg_data} per entry, one-clock registered read.
module ov7670_cfg_rom
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned ROM_AW = 7
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr,
  output logic [15:0]       data
);

  // Entry 0 soft-resets the sensor, so entry 1 must give it time to settle.
  always_ff @(posedge clk) begin
    case (addr)
      ROM_AW'(0): data <= 16'h1280;
      ROM_AW'(1): data <= DELAY_MARK;
      ROM_AW'(2): data <= 16'h1101;
      ROM_AW'(3): data <= 16'h40D0;
      default:    data <= END_MARK;
    endcase
  end

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// Walks the OV7670 register table and drives one SCCB master write per entry,
// with retry on NACK/timeout, a settle delay on DELAY markers and sticky result flags.
module ov7670_cfg_sequencer
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned ROM_AW      = 7,
  parameter int unsigned DELAY_CYC   = 1_000_000,
  parameter int unsigned GAP_CYC     = 2_000,
  parameter int unsigned TIMEOUT_CYC = 100_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_sccb_done,
  input  logic              i_sccb_ack_error,
  output logic              o_sccb_start,
  output logic [7:0]        o_sccb_addr,
  output logic [7:0]        o_sccb_data,
  output logic              o_busy,
  output logic              o_init_done,
  output logic              o_init_fail,
  output logic [ROM_AW-1:0] o_fail_index
);

  localparam int unsigned CNT_MAX =
    (DELAY_CYC > GAP_CYC) ? ((DELAY_CYC > TIMEOUT_CYC) ? DELAY_CYC : TIMEOUT_CYC)
                          : ((GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t               state;
  logic [ROM_AW-1:0]    index;
  logic [RETRY_W-1:0]   retry;
  logic [CNT_W-1:0]     cnt;
  logic                 ack_prev;
  logic [15:0]          rom_word;
  cfg_entry_t           entry;
  logic                 ack_rise;

  ov7670_cfg_rom #(.ROM_AW(ROM_AW)) u_rom (
    .clk  (clk),
    .addr (index),
    .data (rom_word)
  );

  assign entry    = rom_word;
  assign ack_rise = i_sccb_ack_error & ~ack_prev;

  // One counter serves the timeout, gap and delay phases since they never overlap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      index        <= '0;
      retry        <= '0;
      cnt          <= '0;
      ack_prev     <= 1'b0;
      o_sccb_start <= 1'b0;
      o_sccb_addr  <= '0;
      o_sccb_data  <= '0;
      o_busy       <= 1'b0;
      o_init_done  <= 1'b0;
      o_init_fail  <= 1'b0;
      o_fail_index <= '0;
    end else begin
      ack_prev <= i_sccb_ack_error;
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (i_start) begin
            index       <= '0;
            retry       <= '0;
            cnt         <= '0;
            o_init_done <= 1'b0;
            o_init_fail <= 1'b0;
            o_busy      <= 1'b1;
            state       <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LATCH;
        ST_LATCH: begin
          // The last slot acts as END so a table without a terminator cannot run away.
          if (entry == END_MARK || index == {ROM_AW{1'b1}}) begin
            o_busy      <= 1'b0;
            o_init_done <= 1'b1;
            state       <= ST_DONE;
          end else if (entry == DELAY_MARK) begin
            cnt   <= '0;
            state <= ST_DELAY;
          end else begin
            o_sccb_addr <= entry.addr;
            o_sccb_data <= entry.data;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          o_sccb_start <= 1'b1;
          cnt          <= '0;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_sccb_done) begin
            o_sccb_start <= 1'b0;
            retry        <= '0;
            index        <= index + 1'b1;
            cnt          <= '0;
            state        <= ST_GAP;
          end else if (ack_rise || cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            o_sccb_start <= 1'b0;
            cnt          <= '0;
            state        <= ST_ERR_HOLD;
          end else begin
            cnt <= (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
          end
        end
        ST_ERR_HOLD: begin
          // The gap only starts counting once the master has released ack_error.
          if (i_sccb_ack_error) begin
            cnt <= '0;
          end else if (cnt == CNT_W'(GAP_CYC - 1)) begin
            cnt <= '0;
            if (retry == RETRY_W'(MAX_RETRY)) begin
              o_busy       <= 1'b0;
              o_init_fail  <= 1'b1;
              o_fail_index <= index;
              state        <= ST_FAIL;
            end else begin
              retry <= retry + 1'b1;
              state <= ST_ISSUE;
            end
          end else begin
            cnt <= (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == CNT_W'(GAP_CYC - 1)) begin
            cnt   <= '0;
            state <= ST_FETCH;
          end else begin
            cnt <= (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
          end
        end
        ST_DELAY: begin
          if (cnt == CNT_W'(DELAY_CYC - 1)) begin
            cnt   <= '0;
            index <= index + 1'b1;
            state <= ST_FETCH;
          end else begin
            cnt <= (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Scoreboard bench: scenarios queue expected SCCB writes and master responses,
// a master model answers each start and a monitor checks every start pulse.
module tb_ov7670_cfg_sequencer;

  localparam int ROM_AW      = 7;
  localparam int DELAY_CYC   = 200;
  localparam int GAP_CYC     = 20;
  localparam int TIMEOUT_CYC = 100;
  localparam int MAX_RETRY   = 3;

  localparam int R_ACK  = 0;
  localparam int R_NACK = 1;
  localparam int R_NONE = 2;
  localparam int R_BOTH = 3;

  localparam int RESP_LAT  = 10;
  localparam int NACK_HOLD = 1000;
  localparam int PULSE_LEN = RESP_LAT + 1;
  localparam int RUN_LIMIT = 20000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_start = 1'b0;
  logic              i_sccb_done = 1'b0;
  logic              i_sccb_ack_error = 1'b0;
  logic              o_sccb_start;
  logic [7:0]        o_sccb_addr;
  logic [7:0]        o_sccb_data;
  logic              o_busy;
  logic              o_init_done;
  logic              o_init_fail;
  logic [ROM_AW-1:0] o_fail_index;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         len;
    int         ref_kind;
    int         min_gap;
  } exp_t;

  exp_t   exp_q[$];
  int     resp_q[$];
  int     n_checks = 0;
  int     n_fail = 0;
  longint cyc = 0;
  longint last_done_cyc = 0;
  longint last_fall_cyc = 0;

  ov7670_cfg_sequencer #(
    .CLK_HZ      (100_000_000),
    .ROM_AW      (ROM_AW),
    .DELAY_CYC   (DELAY_CYC),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_start          (i_start),
    .i_sccb_done      (i_sccb_done),
    .i_sccb_ack_error (i_sccb_ack_error),
    .o_sccb_start     (o_sccb_start),
    .o_sccb_addr      (o_sccb_addr),
    .o_sccb_data      (o_sccb_data),
    .o_busy           (o_busy),
    .o_init_done      (o_init_done),
    .o_init_fail      (o_init_fail),
    .o_fail_index     (o_fail_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic checkAtLeast(input string name, input longint act, input longint req);
    n_checks++;
    if (act < req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected at least %0d", name, act, req);
    end
  endtask

  task automatic pushExp(input logic [7:0] a, input logic [7:0] d, input int len,
                         input int ref_kind, input int min_gap);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.len = len;
    e.ref_kind = ref_kind;
    e.min_gap = min_gap;
    exp_q.push_back(e);
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, "_start"}, o_sccb_start, 0);
    checkOutput({name, "_addr"}, o_sccb_addr, 0);
    checkOutput({name, "_data"}, o_sccb_data, 0);
    checkOutput({name, "_busy"}, o_busy, 0);
    checkOutput({name, "_done"}, o_init_done, 0);
    checkOutput({name, "_fail"}, o_init_fail, 0);
    checkOutput({name, "_fail_index"}, o_fail_index, 0);
  endtask

  // Pulses i_start, optionally pokes it again while busy, then waits for the run to end.
  task automatic applyStimulus(input string name, input int poke_at);
    int n;
    $display("[TB] scenario %s", name);
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    checkOutput({name, "_busy_after_start"}, o_busy, 1);
    n = 0;
    while (o_busy && n < RUN_LIMIT) begin
      @(negedge clk);
      n++;
      i_start = (n == poke_at);
    end
    i_start = 1'b0;
    checkOutput({name, "_completed_in_time"}, longint'(n < RUN_LIMIT), 1);
    repeat (3) @(negedge clk);
    checkOutput({name, "_all_writes_seen"}, exp_q.size(), 0);
  endtask

  // Master model: answers each rising start with the next queued response.
  initial begin : master_model
    logic prev;
    int   r;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_sccb_start && !prev) begin
        r = (resp_q.size() > 0) ? resp_q.pop_front() : R_ACK;
        if (r != R_NONE) begin
          repeat (RESP_LAT) @(negedge clk);
          if (r == R_ACK) begin
            i_sccb_done = 1'b1;
            last_done_cyc = cyc;
            @(negedge clk);
            i_sccb_done = 1'b0;
          end else if (r == R_NACK) begin
            i_sccb_ack_error = 1'b1;
            repeat (NACK_HOLD) @(negedge clk);
            i_sccb_ack_error = 1'b0;
            last_fall_cyc = cyc;
          end else begin
            i_sccb_done = 1'b1;
            i_sccb_ack_error = 1'b1;
            last_done_cyc = cyc;
            @(negedge clk);
            i_sccb_done = 1'b0;
            repeat (4) @(negedge clk);
            i_sccb_ack_error = 1'b0;
            last_fall_cyc = cyc;
          end
        end
      end
      prev = o_sccb_start;
    end
  end

  // Monitor: pops the expected write on every start pulse and checks its payload and width.
  initial begin : monitor
    logic prev;
    logic active;
    logic changed;
    int   len;
    exp_t cur;
    prev = 1'b0;
    active = 1'b0;
    changed = 1'b0;
    len = 0;
    forever begin
      @(negedge clk);
      if (o_sccb_start && !prev) begin
        len = 1;
        changed = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_start: got write 0x%0h/0x%0h, expected no write",
                   o_sccb_addr, o_sccb_data);
          active = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          active = 1'b1;
          checkOutput("start_addr", o_sccb_addr, cur.addr);
          checkOutput("start_data", o_sccb_data, cur.data);
          if (cur.ref_kind == 1)
            checkAtLeast("delay_after_done", cyc - last_done_cyc, cur.min_gap);
          else if (cur.ref_kind == 2)
            checkAtLeast("gap_after_nack", cyc - last_fall_cyc, cur.min_gap);
        end
      end else if (o_sccb_start) begin
        len++;
        if (active && (o_sccb_addr != cur.addr || o_sccb_data != cur.data)) changed = 1'b1;
      end else if (prev && active) begin
        checkOutput("addr_data_stable", changed, 0);
        if (cur.len > 0) checkOutput("start_width", len, cur.len);
        active = 1'b0;
      end
      prev = o_sccb_start;
    end
  end

  initial begin : watchdog
    #900_000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Normal sequence through the delay marker
    pushExp(8'h12, 8'h80, PULSE_LEN, 0, 0);
    pushExp(8'h11, 8'h01, PULSE_LEN, 1, DELAY_CYC);
    pushExp(8'h40, 8'hD0, PULSE_LEN, 0, 0);
    repeat (3) resp_q.push_back(R_ACK);
    applyStimulus("normal", 0);
    checkOutput("normal_done", o_init_done, 1);
    checkOutput("normal_fail", o_init_fail, 0);
    checkOutput("normal_busy", o_busy, 0);

    // One NACK on 11/01, then a successful retry
    pushExp(8'h12, 8'h80, PULSE_LEN, 0, 0);
    pushExp(8'h11, 8'h01, PULSE_LEN, 1, DELAY_CYC);
    pushExp(8'h11, 8'h01, PULSE_LEN, 2, GAP_CYC);
    pushExp(8'h40, 8'hD0, PULSE_LEN, 0, 0);
    resp_q.push_back(R_ACK);
    resp_q.push_back(R_NACK);
    resp_q.push_back(R_ACK);
    resp_q.push_back(R_ACK);
    applyStimulus("single_nack", 0);
    checkOutput("single_nack_done", o_init_done, 1);
    checkOutput("single_nack_fail", o_init_fail, 0);

    // Persistent NACK on 40/D0
    pushExp(8'h12, 8'h80, PULSE_LEN, 0, 0);
    pushExp(8'h11, 8'h01, PULSE_LEN, 1, DELAY_CYC);
    pushExp(8'h40, 8'hD0, PULSE_LEN, 0, 0);
    repeat (MAX_RETRY) pushExp(8'h40, 8'hD0, PULSE_LEN, 2, GAP_CYC);
    resp_q.push_back(R_ACK);
    resp_q.push_back(R_ACK);
    repeat (MAX_RETRY + 1) resp_q.push_back(R_NACK);
    applyStimulus("persistent_nack", 0);
    checkOutput("persistent_nack_fail", o_init_fail, 1);
    checkOutput("persistent_nack_done", o_init_done, 0);
    checkOutput("persistent_nack_index", o_fail_index, 3);

    // Master never answers the first write
    repeat (MAX_RETRY + 1) begin
      pushExp(8'h12, 8'h80, TIMEOUT_CYC, 0, 0);
      resp_q.push_back(R_NONE);
    end
    applyStimulus("timeout", 0);
    checkOutput("timeout_fail", o_init_fail, 1);
    checkOutput("timeout_done", o_init_done, 0);
    checkOutput("timeout_index", o_fail_index, 0);

    // Reset in the fifth clock of the second WAIT, then a full replay
    $display("[TB] scenario reset_mid_wait");
    pushExp(8'h12, 8'h80, PULSE_LEN, 0, 0);
    pushExp(8'h11, 8'h01, 0, 0, 0);
    resp_q.push_back(R_ACK);
    resp_q.push_back(R_NONE);
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (!(o_sccb_start && o_sccb_addr == 8'h11) && n < RUN_LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reset_mid_wait_reached", longint'(n < RUN_LIMIT), 1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkIdleOutputs("reset_mid_wait");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_mid_wait_queue", exp_q.size(), 0);
    pushExp(8'h12, 8'h80, PULSE_LEN, 0, 0);
    pushExp(8'h11, 8'h01, PULSE_LEN, 1, DELAY_CYC);
    pushExp(8'h40, 8'hD0, PULSE_LEN, 0, 0);
    repeat (3) resp_q.push_back(R_ACK);
    applyStimulus("replay", 0);
    checkOutput("replay_done", o_init_done, 1);

    // Done and ack_error edge together count as success; a start poke while busy is ignored
    pushExp(8'h12, 8'h80, PULSE_LEN, 0, 0);
    pushExp(8'h11, 8'h01, PULSE_LEN, 1, DELAY_CYC);
    pushExp(8'h40, 8'hD0, PULSE_LEN, 0, 0);
    resp_q.push_back(R_ACK);
    resp_q.push_back(R_BOTH);
    resp_q.push_back(R_ACK);
    applyStimulus("simultaneous", 30);
    checkOutput("simultaneous_done", o_init_done, 1);
    checkOutput("simultaneous_fail", o_init_fail, 0);
    checkOutput("simultaneous_busy", o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
